me_lsu: RTL and testbench
=========================

Name: me_lsu

Overview:
- Memory-access stage logic; consumes the me_* outputs of the EX/MEM pipeline register and turns them into data-bus transactions.
- Runs an FSM per access: issues the request, waits for the response, then aligns and extends load data.
- Stalls the pipeline until the access completes.
- Produces the rd write-back data for the MEM/WB register.

Parameters:
- AW, 64, data-bus address width
- DW, 64, data width; equals REG_BUS width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- me_mem_rena  in  1  load
- me_mem_wena  in  1  store
- me_mem_ext_un  in  1  1 = zero-extend load, 0 = sign-extend
- me_mem_byte_enable  in  8  unshifted size mask: 0x01, 0x03, 0x0F or 0xFF
- me_alu_result  in  64  effective address, or ALU result for non-memory instructions
- me_new_rs2_data  in  64  store data, LSB-aligned
- stall_keep  in  1  downstream hold; MEM/WB not accepting
- stall_req  out  1  combinational; freezes PC/IF/ID/EX/EX_ME
- misalign_err  out  1  access crosses an 8-byte boundary
- me_rd_wdata  out  64  write-back value
- dbus_req_valid  out  1  request valid
- dbus_req_ready  in  1  request accepted
- dbus_we  out  1  1 = write
- dbus_addr  out  AW  address {alu_result[63:3], 3'b0}
- dbus_wdata  out  64  store data shifted left by 8*addr[2:0]
- dbus_wstrb  out  8  byte_enable shifted left by addr[2:0]
- dbus_resp_valid  in  1  response for read or write
- dbus_rdata  in  64  read data, doubleword-aligned

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- access = me_mem_rena | me_mem_wena. rena and wena are never both 1; if they are, treat it as a load.
- off = me_alu_result[2:0].
- misalign = access and (byte_enable << off) overflows bit 7; checked as ({8'b0,be} << off) has bits [15:8] nonzero.
- IDLE:
  - With access and not misalign: stall_req=1, next state REQ; latch we, addr, wdata, wstrb, off, ext_un and size into registers.
  - With misalign: misalign_err=1, stall_req=0, no bus activity, me_rd_wdata=0, stay in IDLE.
  - Otherwise: me_rd_wdata=me_alu_result, stall_req=0.
- REQ:
  - dbus_req_valid=1; address, data, strobe and we come from the latched registers and stay stable until accepted.
  - On dbus_req_ready, go to WAIT.
- WAIT:
  - req_valid=0.
  - On dbus_resp_valid, go to DONE. For a load, also capture the extracted value into load_q.
  - Extraction: x = rdata >> (8*off). Byte, half or word is selected by the size mask, then sign- or zero-extended to 64 bits per ext_un. Size 0xFF takes x unchanged.
- DONE:
  - stall_req=0. me_rd_wdata = load_q for a load, 0 for a store.
  - If stall_keep, stay in DONE and hold outputs; otherwise go to IDLE.
- stall_req = 1 in IDLE (access and not misalign), in REQ, and in WAIT.
- Latency with a zero-wait bus: 4 cycles (IDLE, REQ, WAIT, DONE). The bus never returns a response in the same cycle the request is accepted.
- dbus_resp_valid outside WAIT is ignored. dbus_req_ready outside REQ is ignored.
- Reset, asynchronous and possible mid-transaction:
  - state=IDLE; dbus_req_valid=0; load_q=0; all latched registers=0.
  - An in-flight response after reset is ignored.
- Reset values of outputs: stall_req=0, misalign_err=0, me_rd_wdata=0 (with all inputs 0), dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_wstrb=0.

Optional Feature:
- Macro: ME_LSU_ACCESS_CNT_EN.
- Defined:
  - Adds outputs ld_cnt[31:0] and st_cnt[31:0].
  - Each increments by 1 on the WAIT->DONE transition for a load or store respectively.
  - Wraps from 0xFFFFFFFF to 0; reset to 0.
  - A misaligned access does not count.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Non-memory instruction, alu_result=0x1234 -> me_rd_wdata=0x1234 the same cycle, stall_req=0, no dbus_req_valid.
- LB at addr 0x80000005, be=0x01, ext_un=0, rdata=0x00_80_00..., ready and resp immediate:
  - stall_req high for 3 cycles; dbus_addr=0x80000000.
  - In DONE, me_rd_wdata=0xFFFFFFFFFFFFFF80; with ext_un=1, 0x80.
- SH at addr 0x1006, rs2=0xBEEF, be=0x03 -> dbus_wstrb=0xC0, dbus_wdata=0xBEEF000000000000, dbus_we=1; DONE one cycle after resp.
- Bus backpressure: ready low for 3 cycles, resp delayed by 5 -> req_valid and addr stable throughout; stall_req held until DONE; LD result equals rdata.
- LW at offset 6 (be=0x0F) -> misalign_err=1, no request, stall_req=0; with ME_LSU_ACCESS_CNT_EN, ld_cnt unchanged.
- rst_n low while in WAIT, then resp_valid arrives -> state IDLE, req_valid=0, response ignored, stall_req=0; stall_keep in DONE holds me_rd_wdata for 2 cycles.

Source files
------------

// File: rtl/me_lsu.sv
// Memory-access stage: turns EX/MEM load/store requests into data-bus transactions and aligns load data.
// Optional ME_LSU_ACCESS_CNT_EN adds ld_cnt/st_cnt completed-access counters.
module me_lsu #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          me_mem_rena,
  input  logic          me_mem_wena,
  input  logic          me_mem_ext_un,
  input  logic [7:0]    me_mem_byte_enable,
  input  logic [DW-1:0] me_alu_result,
  input  logic [DW-1:0] me_new_rs2_data,
  input  logic          stall_keep,
  output logic          stall_req,
  output logic          misalign_err,
  output logic [DW-1:0] me_rd_wdata,
  output logic          dbus_req_valid,
  input  logic          dbus_req_ready,
  output logic          dbus_we,
  output logic [AW-1:0] dbus_addr,
  output logic [DW-1:0] dbus_wdata,
  output logic [7:0]    dbus_wstrb,
  input  logic          dbus_resp_valid,
  input  logic [DW-1:0] dbus_rdata
`ifdef ME_LSU_ACCESS_CNT_EN
  ,
  output logic [31:0]   ld_cnt,
  output logic [31:0]   st_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic          is_load_q, is_load_d;
  logic          ext_un_q, ext_un_d;
  logic [2:0]    off_q, off_d;
  logic [7:0]    size_q, size_d;
  logic [7:0]    wstrb_q, wstrb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] load_q, load_d;

  logic          access_c;
  logic [2:0]    off_c;
  logic [15:0]   be_shift_c;
  logic          misalign_c;
  logic [DW-1:0] shifted_c;
  logic [DW-1:0] extract_c;

  assign access_c   = me_mem_rena | me_mem_wena;
  assign off_c      = me_alu_result[2:0];
  assign be_shift_c = {8'b0, me_mem_byte_enable} << off_c;
  assign misalign_c = access_c & (|be_shift_c[15:8]);

  // Load alignment: bring the addressed byte to bit 0, then size and extend
  assign shifted_c = dbus_rdata >> {off_q, 3'b000};

  always_comb begin
    extract_c = shifted_c;
    case (size_q)
      8'h01: extract_c = ext_un_q ? DW'(shifted_c[7:0])
                                  : {{(DW-8){shifted_c[7]}}, shifted_c[7:0]};
      8'h03: extract_c = ext_un_q ? DW'(shifted_c[15:0])
                                  : {{(DW-16){shifted_c[15]}}, shifted_c[15:0]};
      8'h0F: extract_c = ext_un_q ? DW'(shifted_c[31:0])
                                  : {{(DW-32){shifted_c[31]}}, shifted_c[31:0]};
      default: extract_c = shifted_c;
    endcase
  end

  // Next state, latched request fields and stage outputs
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    is_load_d    = is_load_q;
    ext_un_d     = ext_un_q;
    off_d        = off_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_d       = load_q;
    stall_req    = 1'b0;
    misalign_err = 1'b0;
    me_rd_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (misalign_c) begin
          misalign_err = 1'b1;
        end else begin
          me_rd_wdata = me_alu_result;
          if (access_c) begin
            stall_req = 1'b1;
            state_d   = S_REQ;
            we_d      = me_mem_wena & ~me_mem_rena;
            is_load_d = me_mem_rena;
            ext_un_d  = me_mem_ext_un;
            off_d     = off_c;
            size_d    = me_mem_byte_enable;
            wstrb_d   = be_shift_c[7:0];
            addr_d    = AW'({me_alu_result[DW-1:3], 3'b000});
            wdata_d   = me_new_rs2_data << {off_c, 3'b000};
          end
        end
      end
      S_REQ: begin
        stall_req = 1'b1;
        if (dbus_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (dbus_resp_valid) begin
          state_d = S_DONE;
          if (is_load_q) load_d = extract_c;
        end
      end
      default: begin
        me_rd_wdata = is_load_q ? load_q : '0;
        if (!stall_keep) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      ext_un_q  <= 1'b0;
      off_q     <= 3'd0;
      size_q    <= 8'd0;
      wstrb_q   <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
      ext_un_q  <= ext_un_d;
      off_q     <= off_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
    end
  end

  assign dbus_req_valid = (state_q == S_REQ);
  assign dbus_we        = we_q;
  assign dbus_addr      = addr_q;
  assign dbus_wdata     = wdata_q;
  assign dbus_wstrb     = wstrb_q;

`ifdef ME_LSU_ACCESS_CNT_EN
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;

  // Count accesses as they complete on the WAIT->DONE transition
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if ((state_q == S_WAIT) && dbus_resp_valid) begin
      if (is_load_q) ld_cnt_d = ld_cnt_q + 32'd1;
      else           st_cnt_d = st_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= 32'd0;
      st_cnt_q <= 32'd0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign ld_cnt = ld_cnt_q;
  assign st_cnt = st_cnt_q;
`endif

endmodule

// File: tb/tb_me_lsu.sv
// Scoreboard bench for me_lsu: randomized loads/stores against a byte-level reference model.
module tb_me_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        me_mem_rena, me_mem_wena, me_mem_ext_un;
  logic [7:0]  me_mem_byte_enable;
  logic [63:0] me_alu_result, me_new_rs2_data;
  logic        stall_keep;
  logic        stall_req, misalign_err;
  logic [63:0] me_rd_wdata;
  logic        dbus_req_valid, dbus_req_ready, dbus_we;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]  dbus_wstrb;
  logic        dbus_resp_valid;
`ifdef ME_LSU_ACCESS_CNT_EN
  logic [31:0] ld_cnt, st_cnt;
`endif

  me_lsu #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .me_mem_rena(me_mem_rena), .me_mem_wena(me_mem_wena), .me_mem_ext_un(me_mem_ext_un),
    .me_mem_byte_enable(me_mem_byte_enable), .me_alu_result(me_alu_result),
    .me_new_rs2_data(me_new_rs2_data), .stall_keep(stall_keep),
    .stall_req(stall_req), .misalign_err(misalign_err), .me_rd_wdata(me_rd_wdata),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_resp_valid(dbus_resp_valid), .dbus_rdata(dbus_rdata)
`ifdef ME_LSU_ACCESS_CNT_EN
    , .ld_cnt(ld_cnt), .st_cnt(st_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [63:0] res_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          busy = 1'b0;
  bit          rd_ovr = 1'b0;
  logic [63:0] rd_val = 64'd0;
  int          ready_cfg = 0;
  int          resp_cfg = 0;
  int unsigned exp_ld = 0, exp_st = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[34:3] * 32'h9E37_79B1;
    return {a[31:0] ^ 32'hA5C3_1E57, lo};
  endfunction

  function automatic logic [63:0] bus_word(input logic [63:0] a);
    return rd_ovr ? rd_val : mem_word(a);
  endfunction

  function automatic int size_of(input logic [7:0] be);
    case (be)
      8'h01: return 1;
      8'h03: return 2;
      8'h0F: return 4;
      default: return 8;
    endcase
  endfunction

  // Reference load: pick n bytes starting at off, fill the rest with sign or zero
  function automatic logic [63:0] exp_load(input logic [63:0] word, input int off,
                                           input logic [7:0] be, input bit un);
    logic [7:0]  b[8];
    logic [63:0] r;
    int          n;
    bit          neg;
    n = size_of(be);
    for (int k = 0; k < 8; k++) b[k] = word[8*k +: 8];
    neg = b[off+n-1][7] && !un;
    r = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[8*i +: 8] = b[off+i];
      else       r[8*i +: 8] = neg ? 8'hFF : 8'h00;
    end
    return r;
  endfunction

  // Bus responder: programmable ready/response delay plus noise outside the live window
  initial begin
    int          cnt;
    int          req_cycles;
    bit          acc;
    bit          waiting;
    logic [63:0] acc_addr, pend_word;
    cnt = 0; req_cycles = 0; waiting = 1'b0; pend_word = 64'd0;
    dbus_req_ready = 1'b0; dbus_resp_valid = 1'b0; dbus_rdata = 64'd0;
    forever begin
      @(negedge clk);
      acc = rst_n && dbus_req_valid && dbus_req_ready;
      acc_addr = dbus_addr;
      @(posedge clk); #1;
      dbus_resp_valid = 1'b0;
      if (acc) begin
        waiting = 1'b1;
        cnt = resp_cfg;
        pend_word = bus_word(acc_addr);
      end
      if (waiting) begin
        if (cnt == 0) begin
          dbus_resp_valid = 1'b1;
          dbus_rdata = pend_word;
          waiting = 1'b0;
        end else cnt--;
      end else if ($urandom_range(3) == 0) begin
        dbus_resp_valid = 1'b1;
        dbus_rdata = {$urandom, $urandom};
      end
      if (dbus_req_valid) begin
        dbus_req_ready = (req_cycles >= ready_cfg);
        req_cycles++;
      end else begin
        req_cycles = 0;
        dbus_req_ready = 1'($urandom_range(1));
      end
    end
  end

  // Monitor: pops expected requests on acceptance and results on each DONE cycle
  always @(negedge clk) begin
    req_t r;
    if (rst_n && dbus_req_valid) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %h expected no request", dbus_addr);
      end else begin
        check64("req_addr_stable", dbus_addr, req_q[0].addr);
        check64("req_we_stable", 64'(dbus_we), 64'(req_q[0].we));
        if (dbus_req_ready) begin
          r = req_q.pop_front();
          if (r.we) begin
            check64("req_wdata", dbus_wdata, r.wdata);
            check64("req_wstrb", 64'(dbus_wstrb), 64'(r.wstrb));
          end
        end
      end
    end
    if (busy && !stall_req) begin
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got %h expected no result", me_rd_wdata);
      end else check64("rd_wdata", me_rd_wdata, res_q.pop_front());
    end
  end

  task automatic check_cnt();
`ifdef ME_LSU_ACCESS_CNT_EN
    check64("ld_cnt", 64'(ld_cnt), 64'(exp_ld));
    check64("st_cnt", 64'(st_cnt), 64'(exp_st));
`endif
  endtask

  task automatic set_idle();
    me_mem_rena = 1'b0; me_mem_wena = 1'b0; me_mem_ext_un = 1'b0;
    me_mem_byte_enable = 8'h00; me_alu_result = 64'd0; me_new_rs2_data = 64'd0;
    stall_keep = 1'b0;
  endtask

  task automatic do_alu(input logic [63:0] alu, input logic [7:0] be);
    @(posedge clk); #1;
    me_mem_rena = 1'b0; me_mem_wena = 1'b0; me_mem_byte_enable = be; me_alu_result = alu;
    #1;
    check64("alu_passthru", me_rd_wdata, alu);
    check64("alu_stall", 64'(stall_req), 64'd0);
    check64("alu_misalign", 64'(misalign_err), 64'd0);
    check64("alu_reqv", 64'(dbus_req_valid), 64'd0);
  endtask

  task automatic do_mis(input bit rd, input bit wr, input logic [7:0] be, input logic [63:0] alu);
    @(posedge clk); #1;
    me_mem_rena = rd; me_mem_wena = wr; me_mem_byte_enable = be; me_alu_result = alu;
    me_new_rs2_data = {$urandom, $urandom};
    #1;
    check64("mis_err", 64'(misalign_err), 64'd1);
    check64("mis_stall", 64'(stall_req), 64'd0);
    check64("mis_rd_wdata", me_rd_wdata, 64'd0);
    @(negedge clk);
    check64("mis_no_req", 64'(dbus_req_valid), 64'd0);
    @(posedge clk); #1;
    set_idle();
    #1;
    check64("mis_stays_idle", 64'(dbus_req_valid), 64'd0);
    check_cnt();
  endtask

  task automatic push_expect(input bit rd, input bit wr, input bit un, input logic [7:0] be,
                             input logic [63:0] alu, input logic [63:0] rs2, input int copies);
    req_t        r;
    int          off, n;
    logic [63:0] res;
    off = int'(alu[2:0]);
    n = size_of(be);
    r.we = wr && !rd;
    r.addr = {alu[63:3], 3'b000};
    r.wstrb = 8'd0;
    r.wdata = 64'd0;
    for (int i = 0; i < n; i++) r.wstrb[off+i] = 1'b1;
    for (int k = 0; k < 8; k++) if (k >= off) r.wdata[8*k +: 8] = rs2[8*(k-off) +: 8];
    res = rd ? exp_load(bus_word(r.addr), off, be, un) : 64'd0;
    req_q.push_back(r);
    for (int c = 0; c < copies; c++) res_q.push_back(res);
  endtask

  task automatic do_mem(input bit rd, input bit wr, input bit un, input logic [7:0] be,
                        input logic [63:0] alu, input logic [63:0] rs2,
                        input int rdy, input int rsp, input int keep);
    int stall_cnt;
    bit done;
    @(posedge clk); #1;
    ready_cfg = rdy; resp_cfg = rsp;
    me_mem_rena = rd; me_mem_wena = wr; me_mem_ext_un = un; me_mem_byte_enable = be;
    me_alu_result = alu; me_new_rs2_data = rs2; stall_keep = (keep > 0);
    push_expect(rd, wr, un, be, alu, rs2, keep + 1);
    busy = 1'b1;
    stall_cnt = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (stall_req) stall_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL mem_timeout: got no DONE within 300 cycles expected completion");
      req_q.delete(); res_q.delete();
    end else begin
      check64("stall_cycles", 64'(stall_cnt), 64'(3 + rdy + rsp));
      if (rd) exp_ld++; else exp_st++;
      check_cnt();
      for (int j = 1; j <= keep; j++) begin
        @(posedge clk); #1;
        if (j == keep) stall_keep = 1'b0;
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    busy = 1'b0;
    set_idle();
  endtask

  task automatic do_reset_in_wait();
    bit accepted;
    @(posedge clk); #1;
    ready_cfg = 0; resp_cfg = 5;
    me_mem_rena = 1'b1; me_mem_wena = 1'b0; me_mem_byte_enable = 8'hFF;
    me_alu_result = 64'h0000_0000_0000_2040;
    push_expect(1'b1, 1'b0, 1'b0, 8'hFF, me_alu_result, 64'd0, 1);
    busy = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (req_q.size() == 0) accepted = 1'b1;
    end
    @(posedge clk); #1;
    busy = 1'b0;
    req_q.delete(); res_q.delete();
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL rst_setup: got no request acceptance expected one");
    end
    rst_n = 1'b0;
    set_idle();
    exp_ld = 0; exp_st = 0;
    #1;
    check64("rst_wait_stall", 64'(stall_req), 64'd0);
    check64("rst_wait_reqv", 64'(dbus_req_valid), 64'd0);
    check64("rst_wait_addr", dbus_addr, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check64("post_rst_stall", 64'(stall_req), 64'd0);
      check64("post_rst_reqv", 64'(dbus_req_valid), 64'd0);
      check64("post_rst_rd", me_rd_wdata, 64'd0);
    end
    check_cnt();
  endtask

  initial begin
    set_idle();
    #1 rst_n = 1'b0;
    #2;
    check64("rst_stall", 64'(stall_req), 64'd0);
    check64("rst_misalign", 64'(misalign_err), 64'd0);
    check64("rst_rd_wdata", me_rd_wdata, 64'd0);
    check64("rst_reqv", 64'(dbus_req_valid), 64'd0);
    check64("rst_we", 64'(dbus_we), 64'd0);
    check64("rst_addr", dbus_addr, 64'd0);
    check64("rst_wdata", dbus_wdata, 64'd0);
    check64("rst_wstrb", 64'(dbus_wstrb), 64'd0);
    check_cnt();
    @(posedge clk); #2;
    rst_n = 1'b1;

    do_alu(64'h1234, 8'h00);
    rd_ovr = 1'b1; rd_val = 64'h0000_8000_0000_0000;
    do_mem(1'b1, 1'b0, 1'b0, 8'h01, 64'h8000_0005, 64'd0, 0, 0, 0);
    do_mem(1'b1, 1'b0, 1'b1, 8'h01, 64'h8000_0005, 64'd0, 0, 0, 0);
    rd_ovr = 1'b0;
    do_mem(1'b0, 1'b1, 1'b0, 8'h03, 64'h1006, 64'hBEEF, 0, 0, 0);
    do_mem(1'b1, 1'b0, 1'b0, 8'hFF, 64'h0000_0000_0000_3000, 64'd0, 3, 5, 0);
    do_mis(1'b1, 1'b0, 8'h0F, 64'h0000_0000_0000_4006);
    do_reset_in_wait();
    do_mem(1'b1, 1'b0, 1'b0, 8'h0F, 64'h0000_0000_0000_5004, 64'd0, 0, 0, 2);
    do_mem(1'b1, 1'b1, 1'b0, 8'h03, 64'h0000_0000_0000_6002, 64'hFFFF_1234, 1, 1, 0);

    for (int t = 0; t < 150; t++) begin
      int          kind, n, off;
      logic [7:0]  be;
      logic [63:0] alu;
      bit          rd, wr;
      kind = int'($urandom_range(9));
      case ($urandom_range(3))
        0: be = 8'h01;
        1: be = 8'h03;
        2: be = 8'h0F;
        default: be = 8'hFF;
      endcase
      n = size_of(be);
      alu = {$urandom, $urandom};
      if (kind < 2) begin
        do_alu(alu, be);
      end else if (kind == 2) begin
        if (n == 1) be = 8'h03;
        n = size_of(be);
        off = int'($urandom_range(7, 9 - n));
        alu[2:0] = 3'(off);
        rd = 1'($urandom_range(1));
        do_mis(rd, !rd, be, alu);
      end else begin
        off = int'($urandom_range(8 - n, 0));
        alu[2:0] = 3'(off);
        rd = 1'($urandom_range(1));
        wr = !rd || ($urandom_range(7) == 0);
        do_mem(rd, wr, 1'($urandom_range(1)), be, alu, {$urandom, $urandom},
               int'($urandom_range(3)), int'($urandom_range(4)), int'($urandom_range(2)));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_cnt();
    if (req_q.size() != 0 || res_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: got %0d req/%0d res pending expected 0/0", req_q.size(), res_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
